// File: rtl/vigenere_stream_cipher_if.sv
// Character stream interface for vigenere_stream_cipher.
// Carries both handshakes of the cipher: the input side (in_valid/in_ready/char_in)
// and the output side (out_valid/out_ready/char_out).
//   master : environment view (drives input chars, accepts output chars)
//   slave  : cipher view (accepts input chars, drives output chars)
interface vigenere_stream_cipher_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] char_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] char_out;

  modport master (
    output in_valid, char_in, out_ready,
    input  in_ready, out_valid, char_out
  );

  modport slave (
    input  in_valid, char_in, out_ready,
    output in_ready, out_valid, char_out
  );
endinterface

// File: rtl/vigenere_stream_cipher.sv
// Streaming Vigenere cipher with runtime key length, encrypt/decrypt modes and
// case-preserving letter mapping. One registered output stage, 1 char/cycle.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   key_arr  : key characters, char i at [8*i+7:8*i], char 0 used first
//   key_len  : active key length (0 -> 1, > MAX_KEY_LEN -> MAX_KEY_LEN)
//   mode     : 0 = encrypt, 1 = decrypt
//   restart  : synchronous pulse, returns key index to 0
//   stream   : in_valid/in_ready/char_in and out_valid/out_ready/char_out handshakes
//   key_idx  : key position to be applied to the next letter
module vigenere_stream_cipher #(
  parameter int unsigned MAX_KEY_LEN = 8,
  parameter int unsigned KEY_IDX_W   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [8*MAX_KEY_LEN-1:0]   key_arr,
  input  logic [KEY_IDX_W:0]         key_len,
  input  logic                       mode,
  input  logic                       restart,
  vigenere_stream_cipher_if.slave    stream,
  output logic [KEY_IDX_W-1:0]       key_idx
);

  localparam logic [KEY_IDX_W:0] MAX_LEN = (KEY_IDX_W+1)'(MAX_KEY_LEN);
  localparam logic [KEY_IDX_W:0] ONE     = (KEY_IDX_W+1)'(1);
  localparam logic [7:0]         SPACE   = 8'd32;

  logic                 out_valid_q;
  logic [7:0]           char_out_q;
  logic [KEY_IDX_W-1:0] key_idx_q;

  logic                 accept;
  logic [KEY_IDX_W:0]   eff_len;
  logic [KEY_IDX_W-1:0] use_idx;
  logic [KEY_IDX_W-1:0] next_idx;
  logic [7:0]           key_byte;
  logic [5:0]           shift;
  logic                 is_lower;
  logic                 is_upper;
  logic                 is_letter;
  logic [7:0]           base;
  logic [5:0]           off;
  logic [5:0]           t;
  logic [7:0]           mapped;

  assign stream.in_ready  = !out_valid_q || stream.out_ready;
  assign stream.out_valid = out_valid_q;
  assign stream.char_out  = char_out_q;
  assign key_idx          = key_idx_q;

  assign accept = stream.in_valid && stream.in_ready;

  always_comb begin
    eff_len = key_len;
    if (key_len == '0)
      eff_len = ONE;
    else if (key_len > MAX_LEN)
      eff_len = MAX_LEN;
  end

  // A stale index left over from a shrunk key_len restarts the key at char 0,
  // exactly like a simultaneous restart.
  always_comb begin
    use_idx = key_idx_q;
    if (restart || ({1'b0, key_idx_q} >= eff_len))
      use_idx = '0;
    next_idx = ({1'b0, use_idx} == (eff_len - ONE)) ? '0 : use_idx + 1'b1;
  end

  always_comb begin
    key_byte = '0;
    for (int unsigned i = 0; i < MAX_KEY_LEN; i++) begin
      if ({1'b0, use_idx} == (KEY_IDX_W+1)'(i))
        key_byte = key_arr[8*i +: 8];
    end
  end

  always_comb begin
    shift = '0;
    if (key_byte >= "a" && key_byte <= "z")
      shift = 6'(key_byte - 8'd97);
    else if (key_byte >= "A" && key_byte <= "Z")
      shift = 6'(key_byte - 8'd65);
  end

  always_comb begin
    is_lower  = (stream.char_in >= "a") && (stream.char_in <= "z");
    is_upper  = (stream.char_in >= "A") && (stream.char_in <= "Z");
    is_letter = is_lower || is_upper;
    base      = is_lower ? 8'd97 : 8'd65;
    off       = 6'(stream.char_in - base);
    // Decrypt adds the additive inverse (26 - s) so both modes share one
    // conditional subtract; the sum never exceeds 51, so 6 bits suffice.
    t         = mode ? (off + 6'd26 - shift) : (off + shift);
    if (t >= 6'd26)
      t = t - 6'd26;
    mapped    = is_letter ? (base + {2'b00, t}) : SPACE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      char_out_q  <= SPACE;
      key_idx_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      char_out_q  <= mapped;
      if (is_letter)
        key_idx_q <= next_idx;
      else if (restart)
        key_idx_q <= '0;
    end else begin
      if (out_valid_q && stream.out_ready)
        out_valid_q <= 1'b0;
      if (restart)
        key_idx_q <= '0;
    end
  end

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// Directed self-checking bench for vigenere_stream_cipher.
module tb_vigenere_stream_cipher;

  logic        clk;
  logic        reset;
  logic [63:0] key_arr;
  logic [3:0]  key_len;
  logic        mode;
  logic        restart;
  logic [2:0]  key_idx;

  int tests;
  int fails;

  vigenere_stream_cipher_if bus ();

  vigenere_stream_cipher #(
    .MAX_KEY_LEN(8),
    .KEY_IDX_W(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key_arr (key_arr),
    .key_len (key_len),
    .mode    (mode),
    .restart (restart),
    .stream  (bus),
    .key_idx (key_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input string s);
    key_arr = '0;
    for (int i = 0; i < s.len(); i++)
      key_arr[8*i +: 8] = s[i];
  endtask

  function automatic bit is_letter(input logic [7:0] c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
  endfunction

  // One accepted character with out_ready=1; output checked #1 after the edge.
  task automatic step(input logic [7:0] c, input logic [7:0] exp_c,
                      input logic [2:0] exp_idx, input logic rs, input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.char_in   = c;
    bus.out_ready = 1'b1;
    restart       = rs;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".char"},  {24'd0, bus.char_out},  {24'd0, exp_c});
    chk({tag, ".idx"},   {29'd0, key_idx},       {29'd0, exp_idx});
  endtask

  task automatic idle_restart(input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    restart       = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".idx0"}, {29'd0, key_idx}, 32'd0);
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Streams a string; the expected key index follows from counting letters.
  task automatic run_stream(input string din, input string dexp, input int start_idx,
                            input int len, input string tag);
    int idx;
    idx = start_idx;
    for (int i = 0; i < din.len(); i++) begin
      if (is_letter(din[i]))
        idx = (idx + 1) % len;
      step(din[i], dexp[i], 3'(idx), 1'b0, $sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    restart       = 1'b0;
    mode          = 1'b0;
    key_len       = 4'd5;
    bus.in_valid  = 1'b0;
    bus.char_in   = 8'd0;
    bus.out_ready = 1'b1;
    set_key("lemon");

    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.char",  {24'd0, bus.char_out},  32'd32);
    chk("rst.idx",   {29'd0, key_idx},       32'd0);
    chk("rst.ready", {31'd0, bus.in_ready},  32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Encrypt with "lemon"
    run_stream("attackatdawn", "lxfopvefrnhr", 0, 5, "enc");

    // Restart alone: index to 0, output register untouched, valid drains
    @(negedge clk);
    bus.in_valid = 1'b0;
    restart      = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_alone.idx",   {29'd0, key_idx},       32'd0);
    chk("rs_alone.char",  {24'd0, bus.char_out},  {24'd0, 8'("r")});
    chk("rs_alone.valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    restart = 1'b0;

    // Case preservation and passthrough
    run_stream("AT ta!", "LX fo ", 0, 5, "case");

    // Decrypt round trip
    idle_restart("dec_rs");
    mode = 1'b1;
    run_stream("lxfopvefrnhr", "attackatdawn", 0, 5, "dec");

    // Decrypt wrap: 'a' with key 'b' -> 'z'
    set_key("b");
    key_len = 4'd1;
    idle_restart("wrap_rs");
    step("a", "z", 3'd0, 1'b0, "wrap");

    // Backpressure
    mode    = 1'b0;
    key_len = 4'd5;
    set_key("lemon");
    idle_restart("bp_rs");
    step("a", "l", 3'd1, 1'b0, "bp0");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.char_in   = "t";
      bus.out_ready = 1'b0;
      #1;
      chk($sformatf("bp_stall%0d.ready", k), {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp_stall%0d.char", k),  {24'd0, bus.char_out},  {24'd0, 8'("l")});
      chk($sformatf("bp_stall%0d.valid", k), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_stall%0d.idx", k),   {29'd0, key_idx},       32'd1);
    end
    run_stream("ttack", "xfopv", 1, 5, "bp");

    // key_len = 0 behaves as length 1
    set_key("b");
    key_len = 4'd0;
    idle_restart("len0_rs");
    run_stream("abc", "bcd", 0, 1, "len0");

    // key_len = 15 clamps to 8 keys
    set_key("bcdefghi");
    key_len = 4'd15;
    idle_restart("len15_rs");
    run_stream("aaaaaaaaa", "bcdefghib", 0, 8, "len15");

    // Restart coinciding with the 3rd letter
    set_key("lemon");
    key_len = 4'd5;
    idle_restart("rsacc_rs");
    step("a", "l", 3'd1, 1'b0, "rsacc0");
    step("t", "x", 3'd2, 1'b0, "rsacc1");
    step("t", "e", 3'd1, 1'b1, "rsacc2");
    step("a", "e", 3'd2, 1'b0, "rsacc3");

    // key_len shrunk below current index: index 0 used, next index 1
    key_len = 4'd2;
    step("a", "l", 3'd1, 1'b0, "shrink");
    key_len = 4'd5;

    // Reset while stalled
    idle_restart("mrst_rs");
    step("a", "l", 3'd1, 1'b0, "mrst0");
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst.hold_valid", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst.char",  {24'd0, bus.char_out},  32'd32);
    chk("mrst.idx",   {29'd0, key_idx},       32'd0);
    @(negedge clk);
    reset = 1'b0;
    step("a", "l", 3'd1, 1'b0, "mrst1");

    // Idle drain
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain.valid", {31'd0, bus.out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
